// File: rtl/light_monitor.sv
// light_monitor: independent safety monitor on the lamp bus (conflict, encoding, sequence, yellow timing, walk, watchdog).
// Optional feature macro MONITOR_FLASH_EN: flash_red toggles on each tick while a fault is latched.
module light_monitor #(
  parameter int MIN_YELLOW    = 3,
  parameter int MAX_HOLD      = 60,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       Rm,
  input  logic       Ym,
  input  logic       Gm,
  input  logic       Rs,
  input  logic       Ys,
  input  logic       Gs,
  input  logic       W,
  input  logic       clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       armed,
  output logic       flash_red
);

  typedef enum logic [1:0] {ARMING = 2'd0, MONITOR = 2'd1, FAULT = 2'd2} state_t;
  typedef enum logic [1:0] {C_RED = 2'd0, C_YEL = 2'd1, C_GRN = 2'd2, C_INV = 2'd3} colour_t;

  localparam logic [3:0] YEL_LIM    = 4'(MIN_YELLOW);
  localparam logic [8:0] HOLD_LIM   = 9'(MAX_HOLD);
  localparam logic [3:0] GLITCH_LIM = 4'(GLITCH_CYCLES);

  function automatic colour_t decode(input logic r, input logic y, input logic g);
    case ({r, y, g})
      3'b100:  return C_RED;
      3'b010:  return C_YEL;
      3'b001:  return C_GRN;
      default: return C_INV;
    endcase
  endfunction

  function automatic logic bad_step(input colour_t from, input colour_t to);
    return ((from == C_GRN) && (to == C_RED)) ||
           ((from == C_RED) && (to == C_YEL)) ||
           ((from == C_YEL) && (to == C_GRN));
  endfunction

  // A transition on the same clock as a tick wins: the count restarts and the tick is dropped.
  function automatic logic [3:0] yel_next(input colour_t prev, input logic chg, input logic t,
                                          input logic [3:0] cnt);
    if (chg) return 4'd0;
    else if (t && (prev == C_YEL) && (cnt != 4'hF)) return cnt + 4'd1;
    else return cnt;
  endfunction

  logic       s_rm_r, s_ym_r, s_gm_r, s_rs_r, s_ys_r, s_gs_r, s_w_r;
  state_t     state_r;
  colour_t    prev_m_r, prev_s_r;
  logic [3:0] yel_m_r, yel_s_r;
  logic [7:0] wd_r;
  logic [2:0] glitch_r;
  logic       fault_r, armed_r;
  logic [2:0] code_r;

  colour_t    cur_m_s, cur_s_s;
  logic       conflict_s, walk_s, invalid_s, chg_m_s, chg_s_s;
  logic       seq_s, short_s, glitch_hit_s, wd_hit_s, exit_s;
  logic [2:0] arm_code_s, mon_code_s;

  // Lamp read-back register; every check below works on these copies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {s_rm_r, s_ym_r, s_gm_r, s_rs_r, s_ys_r, s_gs_r, s_w_r} <= 7'd0;
    end else begin
      {s_rm_r, s_ym_r, s_gm_r, s_rs_r, s_ys_r, s_gs_r, s_w_r} <= {Rm, Ym, Gm, Rs, Ys, Gs, W};
    end
  end

  // Decode and raw check conditions.
  always_comb begin
    cur_m_s      = decode(s_rm_r, s_ym_r, s_gm_r);
    cur_s_s      = decode(s_rs_r, s_ys_r, s_gs_r);
    conflict_s   = (s_ym_r | s_gm_r) & (s_ys_r | s_gs_r);
    walk_s       = s_w_r & (s_ym_r | s_gm_r | s_ys_r | s_gs_r);
    invalid_s    = (cur_m_s == C_INV) || (cur_s_s == C_INV);
    chg_m_s      = (cur_m_s != C_INV) && (cur_m_s != prev_m_r);
    chg_s_s      = (cur_s_s != C_INV) && (cur_s_s != prev_s_r);
    seq_s        = (chg_m_s && bad_step(prev_m_r, cur_m_s)) ||
                   (chg_s_s && bad_step(prev_s_r, cur_s_s));
    short_s      = (chg_m_s && (prev_m_r == C_YEL) && (cur_m_s == C_RED) && (yel_m_r < YEL_LIM)) ||
                   (chg_s_s && (prev_s_r == C_YEL) && (cur_s_s == C_RED) && (yel_s_r < YEL_LIM));
    glitch_hit_s = invalid_s && (({1'b0, glitch_r} + 4'd1) >= GLITCH_LIM);
    wd_hit_s     = tick && !chg_m_s && !chg_s_s && (({1'b0, wd_r} + 9'd1) >= HOLD_LIM);
    exit_s       = clear && !conflict_s && !walk_s && !invalid_s;
  end

  // Cause priority: lowest code wins.
  always_comb begin
    arm_code_s = 3'd0;
    mon_code_s = 3'd0;
    if (conflict_s) begin
      arm_code_s = 3'd1;
    end else if (walk_s) begin
      arm_code_s = 3'd5;
    end else begin
      arm_code_s = 3'd0;
    end
    if (conflict_s)        mon_code_s = 3'd1;
    else if (glitch_hit_s) mon_code_s = 3'd2;
    else if (seq_s)        mon_code_s = 3'd3;
    else if (short_s)      mon_code_s = 3'd4;
    else if (walk_s)       mon_code_s = 3'd5;
    else if (wd_hit_s)     mon_code_s = 3'd6;
    else                   mon_code_s = 3'd0;
  end

  // Monitor FSM with its counters and registered flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ARMING;
      prev_m_r <= C_RED;
      prev_s_r <= C_RED;
      yel_m_r  <= 4'd0;
      yel_s_r  <= 4'd0;
      wd_r     <= 8'd0;
      glitch_r <= 3'd0;
      fault_r  <= 1'b0;
      code_r   <= 3'd0;
      armed_r  <= 1'b0;
    end else begin
      case (state_r)
        ARMING: begin
          if (arm_code_s != 3'd0) begin
            state_r <= FAULT;
            fault_r <= 1'b1;
            code_r  <= arm_code_s;
          end else if (!invalid_s) begin
            state_r  <= MONITOR;
            armed_r  <= 1'b1;
            prev_m_r <= cur_m_s;
            prev_s_r <= cur_s_s;
            yel_m_r  <= 4'd0;
            yel_s_r  <= 4'd0;
            wd_r     <= 8'd0;
            glitch_r <= 3'd0;
          end
        end
        MONITOR: begin
          if (mon_code_s != 3'd0) begin
            state_r <= FAULT;
            fault_r <= 1'b1;
            code_r  <= mon_code_s;
            armed_r <= 1'b0;
          end else begin
            if (chg_m_s) prev_m_r <= cur_m_s;
            if (chg_s_s) prev_s_r <= cur_s_s;
            yel_m_r  <= yel_next(prev_m_r, chg_m_s, tick, yel_m_r);
            yel_s_r  <= yel_next(prev_s_r, chg_s_s, tick, yel_s_r);
            glitch_r <= invalid_s ? glitch_r + 3'd1 : 3'd0;
            if (chg_m_s || chg_s_s)            wd_r <= 8'd0;
            else if (tick && (wd_r != 8'hFF)) wd_r <= wd_r + 8'd1;
          end
        end
        FAULT: begin
          if (exit_s) begin
            state_r <= ARMING;
            fault_r <= 1'b0;
            code_r  <= 3'd0;
          end
        end
        default: begin
          state_r <= ARMING;
          fault_r <= 1'b0;
          code_r  <= 3'd0;
          armed_r <= 1'b0;
        end
      endcase
    end
  end

  assign fault      = fault_r;
  assign fault_code = code_r;
  assign armed      = armed_r;

`ifdef MONITOR_FLASH_EN
  logic flash_r;

  // Flash toggles per tick while latched and drops on the edge that leaves FAULT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_r <= 1'b0;
    end else if ((state_r != FAULT) || exit_s) begin
      flash_r <= 1'b0;
    end else if (tick) begin
      flash_r <= ~flash_r;
    end
  end

  assign flash_red = flash_r;
`else
  assign flash_red = 1'b0;
`endif

endmodule

// File: tb/tb_light_monitor.sv
// Randomized + directed bench for light_monitor against a timestamp-based reference model.
module tb_light_monitor;
  localparam int MIN_YELLOW    = 3;
  localparam int MAX_HOLD      = 60;
  localparam int GLITCH_CYCLES = 4;

  logic       clk = 1'b0;
  logic       reset_n, tick, clear;
  logic       Rm, Ym, Gm, Rs, Ys, Gs, W;
  logic       fault, armed, flash_red;
  logic [2:0] fault_code;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  light_monitor #(.MIN_YELLOW(MIN_YELLOW), .MAX_HOLD(MAX_HOLD), .GLITCH_CYCLES(GLITCH_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .Rm(Rm), .Ym(Ym), .Gm(Gm), .Rs(Rs), .Ys(Ys), .Gs(Gs), .W(W),
    .clear(clear), .fault(fault), .fault_code(fault_code), .armed(armed), .flash_red(flash_red)
  );

  // Reference model: mode 0 arming, 1 monitoring, 2 faulted; timing kept as absolute tick stamps.
  int         m_mode, m_code, m_ticks, m_last_chg, m_inv_run;
  int         m_prev [2];
  int         m_enter[2];
  bit         m_flash;
  logic [6:0] m_s;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int colour(input logic [2:0] ryg);
    case (ryg)
      3'b100:  return 0;
      3'b010:  return 1;
      3'b001:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [2:0] col(input int c);
    case (c)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [6:0] lamps(input int mc, input int sc, input logic w);
    return {col(mc), col(sc), w};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_code = 0; m_ticks = 0; m_last_chg = 0; m_inv_run = 0;
    m_flash = 1'b0; m_s = 7'd0;
    m_prev[0] = 0; m_prev[1] = 0; m_enter[0] = 0; m_enter[1] = 0;
  endtask

  // Legal colour order is R(0) -> G(2) -> Y(1) -> R(0), i.e. next = (prev + 2) mod 3.
  task automatic model_step(input logic tk, input logic clr, input logic [6:0] lv);
    int c[2];
    bit nr[2];
    bit conf, walk, inv, seq, shorty, chg, glitch, wdog;
    int t_before, t_after;
    c[0] = colour(m_s[6:4]);
    c[1] = colour(m_s[3:1]);
    nr[0] = m_s[5] | m_s[4];
    nr[1] = m_s[2] | m_s[1];
    conf = nr[0] && nr[1];
    walk = m_s[0] && (nr[0] || nr[1]);
    inv  = (c[0] < 0) || (c[1] < 0);
    t_before = m_ticks;
    t_after  = m_ticks + int'(tk);
    m_ticks  = t_after;
    case (m_mode)
      0: begin
        if (conf) begin
          m_mode = 2; m_code = 1;
        end else if (walk) begin
          m_mode = 2; m_code = 5;
        end else if (!inv) begin
          m_mode = 1;
          for (int i = 0; i < 2; i++) begin
            m_prev[i] = c[i]; m_enter[i] = t_after;
          end
          m_last_chg = t_after;
          m_inv_run  = 0;
        end
      end
      1: begin
        seq = 0; shorty = 0; chg = 0;
        for (int i = 0; i < 2; i++) begin
          if (c[i] >= 0 && c[i] != m_prev[i]) begin
            chg = 1;
            if (c[i] != (m_prev[i] + 2) % 3) seq = 1;
            else if (m_prev[i] == 1 && (t_before - m_enter[i]) < MIN_YELLOW) shorty = 1;
            m_prev[i]  = c[i];
            m_enter[i] = t_after;
          end
        end
        m_inv_run = inv ? m_inv_run + 1 : 0;
        glitch = (m_inv_run >= GLITCH_CYCLES);
        if (chg) m_last_chg = t_after;
        wdog = !chg && tk && ((t_after - m_last_chg) >= MAX_HOLD);
        m_code = conf ? 1 : glitch ? 2 : seq ? 3 : shorty ? 4 : walk ? 5 : wdog ? 6 : 0;
        if (m_code != 0) m_mode = 2;
      end
      default: begin
        if (clr && !conf && !walk && !inv) begin
          m_mode = 0; m_code = 0; m_flash = 1'b0;
        end else if (tk) begin
`ifdef MONITOR_FLASH_EN
          m_flash = !m_flash;
`endif
        end
      end
    endcase
    m_s = lv;
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge, compare 1 ns later.
  task automatic cyc(input logic [6:0] lv, input logic tk, input logic clr);
    {Rm, Ym, Gm, Rs, Ys, Gs, W} = lv;
    tick  = tk;
    clear = clr;
    @(posedge clk);
    model_step(tk, clr, lv);
    #1;
    check("fault", int'(fault), int'(m_mode == 2));
    check("fault_code", int'(fault_code), m_code);
    check("armed", int'(armed), int'(m_mode == 1));
    check("flash_red", int'(flash_red), int'(m_flash));
    @(negedge clk);
  endtask

  // Each unit is three clocks with the tick on the last one, so ticks never land on a transition.
  task automatic hold_ticks(input logic [6:0] lv, input int n);
    for (int k = 0; k < n; k++) begin
      cyc(lv, 1'b0, 1'b0);
      cyc(lv, 1'b0, 1'b0);
      cyc(lv, 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick = 1'b0; clear = 1'b0;
    {Rm, Ym, Gm, Rs, Ys, Gs, W} = 7'd0;
    #2;
    model_reset();
    check("rst_fault", int'(fault), 0);
    check("rst_code", int'(fault_code), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_flash", int'(flash_red), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic recover();
    for (int k = 0; k < 3; k++) cyc(lamps(0, 0, 1'b0), 1'b0, 1'b1);
    check("recover_fault", int'(fault), 0);
    check("recover_armed", int'(armed), 1);
    cyc(lamps(0, 0, 1'b0), 1'b0, 1'b0);
  endtask

  logic [6:0] allred, lv, bad;
  logic       clr;
  int         mc, sc, len, r;

  initial begin
    reset_n = 1'b0; tick = 1'b0; clear = 1'b0;
    {Rm, Ym, Gm, Rs, Ys, Gs, W} = 7'd0;
    allred = lamps(0, 0, 1'b0);
    model_reset();
    @(negedge clk);
    do_reset();

    cyc(allred, 1'b0, 1'b0);
    check("arm_wait", int'(armed), 0);
    cyc(allred, 1'b0, 1'b0);
    check("arm_latency", int'(armed), 1);

    // Both approaches green in the same clock.
    cyc(lamps(2, 2, 1'b0), 1'b0, 1'b0);
    cyc(lamps(2, 2, 1'b0), 1'b0, 1'b0);
    check("conflict_code", int'(fault_code), 1);
    recover();

    // Yellow held two ticks is too short; three is enough.
    hold_ticks(lamps(2, 0, 1'b0), 1);
    hold_ticks(lamps(1, 0, 1'b0), 2);
    hold_ticks(allred, 1);
    check("short_yellow", int'(fault_code), 4);
    recover();
    hold_ticks(lamps(2, 0, 1'b0), 1);
    hold_ticks(lamps(1, 0, 1'b0), 3);
    hold_ticks(allred, 1);
    check("yellow_ok", int'(fault), 0);

    // Invalid main encoding for 3 clocks is tolerated, 4 is not.
    bad = {3'b110, 3'b100, 1'b0};
    for (int k = 0; k < 3; k++) cyc(bad, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(allred, 1'b0, 1'b0);
    check("glitch_3", int'(fault), 0);
    for (int k = 0; k < 4; k++) cyc(bad, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) cyc(allred, 1'b0, 1'b0);
    check("glitch_4", int'(fault_code), 2);
    recover();

    hold_ticks(lamps(2, 0, 1'b0), 1);
    cyc(allred, 1'b0, 1'b0);
    cyc(allred, 1'b0, 1'b0);
    check("seq_g_to_r", int'(fault_code), 3);
    recover();

    // Conflict, illegal side step and walk together: conflict must be reported.
    hold_ticks(lamps(2, 0, 1'b0), 1);
    cyc(lamps(2, 1, 1'b1), 1'b0, 1'b0);
    cyc(lamps(2, 1, 1'b1), 1'b0, 1'b0);
    check("priority", int'(fault_code), 1);
    recover();

    hold_ticks(lamps(2, 0, 1'b0), 1);
    cyc(lamps(2, 0, 1'b1), 1'b0, 1'b0);
    cyc(lamps(2, 0, 1'b1), 1'b0, 1'b0);
    check("walk", int'(fault_code), 5);
    recover();

    hold_ticks(allred, MAX_HOLD - 1);
    check("wd_before", int'(fault), 0);
    hold_ticks(allred, 1);
    check("wd_code", int'(fault_code), 6);
    for (int k = 0; k < 3; k++) begin
      hold_ticks(allred, 1);
`ifdef MONITOR_FLASH_EN
      check("flash_seq", int'(flash_red), int'(k % 2 == 0));
`else
      check("flash_off", int'(flash_red), 0);
`endif
    end
    recover();

    // Reset while faulted drops everything at once.
    cyc(lamps(2, 2, 1'b0), 1'b0, 1'b0);
    cyc(lamps(2, 2, 1'b0), 1'b0, 1'b0);
    check("pre_reset_fault", int'(fault), 1);
    do_reset();
    cyc(allred, 1'b0, 1'b0);
    cyc(allred, 1'b0, 1'b0);

    // Random walk: mostly legal steps with random colours, invalid codes, walk requests and clears.
    mc = 0; sc = 0;
    for (int ep = 0; ep < 400; ep++) begin
      clr = (m_mode == 2) && ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 8);
      r   = $urandom_range(0, 99);
      if (clr) begin
        mc = 0; sc = 0;
        lv = allred;
      end else begin
        if (r < 70) begin
          if ($urandom_range(0, 1) == 0) mc = (mc + 2) % 3;
          else sc = (sc + 2) % 3;
        end else if (r < 82) begin
          mc = $urandom_range(0, 2);
        end else if (r < 94) begin
          sc = $urandom_range(0, 2);
        end
        lv = lamps(mc, sc, ($urandom_range(0, 15) == 0));
        if (r >= 94) begin
          lv[6:4] = 3'($urandom);
          len = $urandom_range(1, 5);
        end
      end
      for (int k = 0; k < len; k++) cyc(lv, ($urandom_range(0, 2) == 0), clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
